acl2_sample_hex_formatter: RTL and testbench
============================================

Name: acl2_sample_hex_formatter

Overview:
Downstream consumer of the PMOD ACL2 custom driver's 8-byte measurement vector and its one-cycle valid pulse. Each accepted sample becomes a fixed 29-character ASCII text line, "X=hhhh Y=hhhh Z=hhhh T=hhhh\r\n". The line streams one byte at a time over a valid/ready handshake into the UART TX FIFO stage. The block provides one-deep sample buffering, decimation, and drop accounting, so the UART can lag the sensor without stalling the driver.

Parameters:
parm_decimate, 1, forward one of every N accepted samples; legal range 1..255.
parm_hex_uppercase, 1, 1 emits 'A'-'F' for hex digits 10-15; 0 emits 'a'-'f'.

Ports:
i_clk_20mhz  in  1  system clock, 20 MHz.
i_rstn_20mhz  in  1  reset, asynchronous, active-low.
i_enable  in  1  level; when 0, new samples are ignored.
i_data_3axis_temp  in  64  byte order from [63:56] down: XL,XH,YL,YH,ZL,ZH,TL,TH.
i_data_valid  in  1  one-cycle strobe; i_data_3axis_temp is valid on this cycle.
o_tx_data  out  8  ASCII character.
o_tx_valid  out  1  character available.
i_tx_ready  in  1  sink accepts; a transfer occurs when o_tx_valid and i_tx_ready are both 1.
o_busy  out  1  1 while a line is being emitted or a sample is pending.
o_drop_count  out  8  saturating count of samples overwritten in the pending buffer.

Behaviour:
- Reset: asynchronous assert, synchronous release. All outputs are 0. FSM in ST_IDLE. Pending buffer empty. Decimation counter 0. Character index 0.
- Input stage, evaluated on i_data_valid=1 with i_enable=1:
  - A sample is accepted when the decimation counter is 0.
  - The counter increments every such strobe and wraps at parm_decimate-1. With parm_decimate=1 every sample is accepted.
  - A decimated-away sample does not count as a drop.
- Pending buffer (one sample, one flag):
  - An accepted sample is written to the buffer and the flag is set.
  - If the flag is already set and is not being cleared this cycle, the new sample overwrites the old one and o_drop_count increments, saturating at 255.
  - Same-cycle arrival and consumption: the consumption clears the flag, the new sample then sets it, and no drop is counted.
- Axis words: X={XH,XL}, Y={YH,YL}, Z={ZH,ZL}, T={TH,TL}. Each word prints as 4 hex digits, MS nibble first.
- Nibble to ASCII: 0-9 map to 0x30-0x39. 10-15 map to 0x41-0x46 when parm_hex_uppercase=1, or 0x61-0x66 when 0.
- Character index 0..28:
  - 0 'X', 1 '=', 2-5 X digits, 6 ' '.
  - 7 'Y', 8 '=', 9-12 Y digits, 13 ' '.
  - 14 'Z', 15 '=', 16-19 Z digits, 20 ' '.
  - 21 'T', 22 '=', 23-26 T digits.
  - 27 0x0D, 28 0x0A.
- FSM states:
  - ST_IDLE: o_tx_valid=0. If the pending flag is set, copy the buffer to the working register, clear the flag, set index=0, go to ST_LOAD.
  - ST_LOAD: one cycle. Register the character for index into o_tx_data, then go to ST_SEND.
  - ST_SEND: o_tx_valid=1. o_tx_data is held stable while i_tx_ready=0.
    - On a transfer with index<28: index+1, go to ST_LOAD.
    - On a transfer with index=28: go to ST_IDLE.
- Latency: i_data_valid to the first o_tx_valid is 3 cycles when idle. Throughput is at most 1 character per 2 cycles.
- The working register is never modified mid-line. A new sample arriving during a line only affects the pending buffer.
- i_enable falling mid-line: the current line completes and any pending sample is still emitted. Only new samples are ignored.
- o_busy = (state≠ST_IDLE) | pending flag.
- Asserting reset mid-line aborts the line immediately. o_tx_valid drops to 0 asynchronously.
- The o_drop_count register holds its value; it clears only on reset.

Test Plan:
- Reset release, then i_data_3axis_temp=64'h3412_7856_BC9A_F0DE with a one-cycle valid, i_tx_ready=1 → exactly 29 bytes "X=1234 Y=5678 Z=9ABC T=DEF0\r\n"; first o_tx_valid 3 cycles after the strobe; o_busy falls after the 0x0A transfer.
- Same sample with parm_hex_uppercase=0 and i_tx_ready toggling randomly → "…Z=9abc T=def0\r\n"; o_tx_data stable throughout every stalled cycle.
- i_tx_ready held 0 during line A; samples B, C, D strobed → after A completes, only D is emitted; o_drop_count=2.
- parm_decimate=3, six samples S0..S5 with the sink always ready → only S0 and S3 lines are emitted; o_drop_count=0.
- Reset asserted at character index 10 → o_tx_valid=0 immediately; after release, a new sample produces a full fresh line beginning 'X'.
- i_enable=0 while a sample strobes → no output and o_busy stays 0. i_enable deasserted mid-line → that line completes all 29 characters.

Source files
------------

// File: rtl/acl2_sample_hex_formatter.sv
// acl2_sample_hex_formatter: turns ACL2 sample vectors into "X=hhhh Y=hhhh Z=hhhh T=hhhh\r\n" byte streams
module acl2_sample_hex_formatter #(
  parameter int unsigned parm_decimate      = 1,
  parameter bit          parm_hex_uppercase = 1'b1
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic        i_enable,
  input  logic [63:0] i_data_3axis_temp,
  input  logic        i_data_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic [7:0]  o_drop_count
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;
  localparam logic [7:0] DEC_LAST = 8'(parm_decimate - 1);
  state_t      state_q;
  logic [7:0]  dec_q, dec_d;
  logic        pend_q;
  logic [63:0] pend_buf_q, work_q;
  logic [4:0]  idx_q;
  logic [7:0]  tx_data_q, drop_q;
  logic        tx_valid_q;
  logic        strobe_s, accept_s, consume_s;
  logic [1:0]  fld_s;
  logic [4:0]  off_s;
  logic [2:0]  pos_s;
  logic [15:0] word_s;
  logic [3:0]  nib_s;
  logic [7:0]  hex_s, letter_s, char_s;
  // Decimation: strobes while enabled advance the counter, only slot 0 is accepted.
  always_comb begin
    strobe_s  = i_data_valid & i_enable;
    accept_s  = strobe_s & (dec_q == 8'd0);
    consume_s = (state_q == ST_IDLE) & pend_q;
    dec_d     = !strobe_s ? dec_q : (dec_q >= DEC_LAST) ? 8'd0 : dec_q + 8'd1;
  end
  // Character generator: field/position from index, then nibble-to-ASCII.
  always_comb begin
    fld_s    = (idx_q < 5'd7) ? 2'd0 : (idx_q < 5'd14) ? 2'd1 : (idx_q < 5'd21) ? 2'd2 : 2'd3;
    off_s    = idx_q - 5'(fld_s) * 5'd7;
    pos_s    = off_s[2:0];
    word_s   = (fld_s == 2'd0) ? {work_q[55:48], work_q[63:56]} :
               (fld_s == 2'd1) ? {work_q[39:32], work_q[47:40]} :
               (fld_s == 2'd2) ? {work_q[23:16], work_q[31:24]} :
                                 {work_q[7:0],   work_q[15:8]};
    nib_s    = (pos_s == 3'd2) ? word_s[15:12] :
               (pos_s == 3'd3) ? word_s[11:8]  :
               (pos_s == 3'd4) ? word_s[7:4]   : word_s[3:0];
    hex_s    = (nib_s < 4'd10) ? 8'h30 + {4'h0, nib_s} :
               (parm_hex_uppercase ? 8'h37 : 8'h57) + {4'h0, nib_s};
    letter_s = (fld_s == 2'd0) ? 8'h58 : (fld_s == 2'd1) ? 8'h59 : (fld_s == 2'd2) ? 8'h5A : 8'h54;
    char_s   = (idx_q == 5'd27) ? 8'h0D :
               (idx_q == 5'd28) ? 8'h0A :
               (pos_s == 3'd0)  ? letter_s :
               (pos_s == 3'd1)  ? 8'h3D :
               (pos_s == 3'd6)  ? 8'h20 : hex_s;
  end
  // Input stage: decimation counter, one-deep pending buffer and saturating drop counter.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      dec_q      <= 8'd0;
      pend_q     <= 1'b0;
      pend_buf_q <= 64'd0;
      drop_q     <= 8'd0;
    end else begin
      dec_q <= dec_d;
      if (accept_s) begin
        pend_buf_q <= i_data_3axis_temp;
        pend_q     <= 1'b1;
        if (pend_q && !consume_s && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end else if (consume_s) begin
        pend_q <= 1'b0;
      end
    end
  end
  // Line emitter: latch a pending sample, then alternate load/send for each of 29 characters.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      work_q     <= 64'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_valid_q <= 1'b0;
          if (pend_q) begin
            work_q  <= pend_buf_q;
            idx_q   <= 5'd0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_data_q  <= char_s;
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (i_tx_ready) begin
            tx_valid_q <= 1'b0;
            if (idx_q == 5'd28) state_q <= ST_IDLE;
            else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_busy       = (state_q != ST_IDLE) | pend_q;
  assign o_drop_count = drop_q;
endmodule

// File: tb/tb_acl2_sample_hex_formatter.sv
// tb_acl2_sample_hex_formatter: scoreboard bench over three parameterisations of the formatter
`timescale 1ns/1ps
module tb_acl2_sample_hex_formatter;
  localparam logic [63:0] SA = 64'h3412_7856_BC9A_F0DE;
  localparam logic [63:0] SD = 64'hEFBE_ADDE_0DF0_FECA;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] d [3];
  logic v [3], rdy [3], en [3];
  logic [7:0] txd [3];
  logic txv [3], busy [3];
  logic [7:0] drop [3];
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  always #25 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      acl2_sample_hex_formatter #(
        .parm_decimate(g == 2 ? 3 : 1),
        .parm_hex_uppercase(g == 1 ? 1'b0 : 1'b1)
      ) u_dut (
        .i_clk_20mhz(clk),
        .i_rstn_20mhz(rst_n),
        .i_enable(en[g]),
        .i_data_3axis_temp(d[g]),
        .i_data_valid(v[g]),
        .o_tx_data(txd[g]),
        .o_tx_valid(txv[g]),
        .i_tx_ready(rdy[g]),
        .o_busy(busy[g]),
        .o_drop_count(drop[g])
      );
    end
  endgenerate
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_line(input string s);
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask
  task automatic strobe(input int i, input logic [63:0] x);
    d[i] = x;
    v[i] = 1'b1;
    tick();
    v[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_within_budget", n < 3000, 1);
  endtask
  task automatic wait_valid(input int i);
    int n = 0;
    while (!txv[i] && n < 100) begin
      tick();
      n++;
    end
    chk("valid_within_budget", n < 100, 1);
  endtask
  task automatic monitor();
    logic stall [3];
    logic [7:0] hold [3];
    for (int i = 0; i < 3; i++) begin
      stall[i] = 1'b0;
      hold[i]  = 8'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) stall[i] = 1'b0;
        else begin
          if (stall[i]) begin
            chk("stall_valid_held", txv[i], 1);
            chk("stall_data_held", txd[i], hold[i]);
          end
          if (txv[i] && rdy[i]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: inst %0d got %0h expected none", i, txd[i]);
            end else chk("tx_byte", txd[i], exp_q.pop_front());
          end
          stall[i] = txv[i] && !rdy[i];
          hold[i]  = txd[i];
        end
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [63:0] s6 [6];
    s6 = '{SA, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, SD,
           64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555};
    for (int i = 0; i < 3; i++) begin
      d[i] = 64'd0; v[i] = 1'b0; rdy[i] = 1'b1; en[i] = 1'b1;
    end
    fork
      monitor();
    join_none
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx_data", txd[i], 0);
      chk("reset_tx_valid", txv[i], 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_drop", drop[i], 0);
    end
    rst_n = 1'b1;
    tick();
    push_line("X=1234 Y=5678 Z=9ABC T=DEF0");
    strobe(0, SA);
    chk("busy_after_strobe", busy[0], 1);
    n = 0;
    while (!txv[0] && n < 10) begin
      tick();
      n++;
    end
    chk("first_valid_latency", n, 2);
    wait_idle(0);
    chk("line_upper_drained", exp_q.size(), 0);
    push_line("X=1234 Y=5678 Z=9abc T=def0");
    strobe(1, SA);
    n = 0;
    while (busy[1] && n < 3000) begin
      rdy[1] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("random_ready_budget", n < 3000, 1);
    rdy[1] = 1'b1;
    chk("line_lower_drained", exp_q.size(), 0);
    rdy[0] = 1'b0;
    push_line("X=1234 Y=5678 Z=9ABC T=DEF0");
    push_line("X=BEEF Y=DEAD Z=F00D T=CAFE");
    strobe(0, SA);
    wait_valid(0);
    strobe(0, 64'h1111_2222_3333_4444);
    strobe(0, 64'h5555_6666_7777_8888);
    strobe(0, SD);
    chk("drop_after_overwrites", drop[0], 2);
    chk("busy_while_stalled", busy[0], 1);
    repeat (4) tick();
    rdy[0] = 1'b1;
    wait_idle(0);
    chk("drop_held", drop[0], 2);
    chk("overwrite_drained", exp_q.size(), 0);
    push_line("X=1234 Y=5678 Z=9ABC T=DEF0");
    push_line("X=BEEF Y=DEAD Z=F00D T=CAFE");
    for (int k = 0; k < 6; k++) strobe(2, s6[k]);
    wait_idle(2);
    chk("decimate_no_drop", drop[2], 0);
    chk("decimate_drained", exp_q.size(), 0);
    push_line("X=1234 Y=5678 Z=9ABC T=DEF0");
    strobe(0, SA);
    n = 0;
    while (!(exp_q.size() <= 19 && txv[0]) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_index10_budget", n < 200, 1);
    chk("index10_remaining", exp_q.size(), 19);
    rst_n = 1'b0;
    #1;
    chk("abort_valid_low", txv[0], 0);
    chk("abort_busy_low", busy[0], 0);
    exp_q.delete();
    tick();
    tick();
    chk("abort_drop_cleared", drop[0], 0);
    rst_n = 1'b1;
    tick();
    push_line("X=BEEF Y=DEAD Z=F00D T=CAFE");
    strobe(0, SD);
    wait_idle(0);
    chk("fresh_line_drained", exp_q.size(), 0);
    en[0] = 1'b0;
    strobe(0, SA);
    for (int k = 0; k < 5; k++) begin
      chk("disabled_busy", busy[0], 0);
      chk("disabled_valid", txv[0], 0);
      tick();
    end
    en[0] = 1'b1;
    push_line("X=1234 Y=5678 Z=9ABC T=DEF0");
    strobe(0, SA);
    wait_valid(0);
    en[0] = 1'b0;
    wait_idle(0);
    chk("enable_drop_line_drained", exp_q.size(), 0);
    en[0] = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
